gravity_fall_ctrl: RTL
======================

Name: gravity_fall_ctrl

Overview:
- Consumes the periodic `tick_gravity` pulse from the level-dependent tick generator, plus single-cycle player-move pulses.
- Owns the active piece's position and rotation. Moves the piece down on each gravity tick and left, right or rotated on request.
- Every candidate move is validated through a request/acknowledge handshake with the board collision checker.
- Emits a one-cycle `lock` pulse when the piece comes to rest, and raises `game_over` when a spawn position is blocked.

Parameters:
BOARD_W, 10, board width in cells; legal x is 0..BOARD_W-1
SPAWN_X, 3, x of a newly spawned piece
SPAWN_Y, 0, y of a newly spawned piece
LOCK_TICKS, 2, consecutive rejected down-moves that cause a lock (1..7)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; in IDLE or OVER, begins a new game
tick_gravity  input  1  one-cycle gravity pulse from the tick generator
move_left  input  1  one-cycle pulse, request x-1
move_right  input  1  one-cycle pulse, request x+1
rotate  input  1  one-cycle pulse, request rot+1 (mod 4)
chk_req  output  1  collision-check request
chk_x  output  4  candidate x
chk_y  output  5  candidate y
chk_rot  output  2  candidate rotation
chk_ack  input  1  checker done; valid for one cycle
chk_hit  input  1  candidate collides; sampled only when chk_ack=1
piece_x  output  4  current x
piece_y  output  5  current y
piece_rot  output  2  current rotation
active  output  1  a piece is live (FALLING or CHECK)
lock  output  1  one-cycle pulse; piece_* hold the resting position
game_over  output  1  level; held until `start`

Behaviour:
- Reset:
  - state = IDLE; all outputs = 0.
  - piece_x = SPAWN_X, piece_y = SPAWN_Y, piece_rot = 0.
  - Pending flags and lock_cnt = 0.
- Pending flags:
  - There are four flags: down, left, right, rot. Each input pulse sets its flag in any state except IDLE and OVER, where pulses are ignored.
  - A flag is cleared in the cycle its check is issued. A pulse arriving in that same cycle is merged into the issued check and does not re-set the flag.
- States:
  - IDLE: on `start`, go to SPAWN. `game_over` is cleared on the same edge.
  - SPAWN:
    - Load piece_* = (SPAWN_X, SPAWN_Y, 0) and clear lock_cnt.
    - Issue a check of the spawn position.
    - On ack: hit=0 goes to FALLING; hit=1 goes to OVER.
  - FALLING: service the highest-priority pending flag in the order down > left > right > rot, by driving the candidate and going to CHECK. With no flag pending, stay in FALLING.
  - Local rejects in FALLING (no check issued, flag cleared, return to FALLING):
    - left when piece_x = 0;
    - right when piece_x = BOARD_W-1.
  - CHECK:
    - chk_req = 1, with chk_x/y/rot stable until the cycle chk_ack = 1; chk_req drops in the cycle after ack.
    - Candidates: down is (x, y+1, rot); left is (x-1, y, rot); right is (x+1, y, rot); rotate is (x, y, rot+1 mod 4).
    - hit=0: piece_* take the candidate on the next edge. A successful down clears lock_cnt; return to FALLING.
    - hit=1 on a lateral move or rotate: no change; return to FALLING.
    - hit=1 on down: lock_cnt increments. If the new value equals LOCK_TICKS, go to LOCK; otherwise return to FALLING.
    - Lateral moves never reset lock_cnt.
  - LOCK: `lock` = 1 for exactly one cycle with unchanged piece_*. Clear all pending flags and go to SPAWN next cycle.
  - OVER: `game_over` = 1, `active` = 0. On `start`, go to SPAWN.
- Latency:
  - `start` to chk_req = 1: 1 cycle.
  - Ack with hit=0 to piece_* updated: 1 cycle.
  - Checker bandwidth is 1 outstanding request; a request is never issued while another is unacknowledged.
- Timing assumptions:
  - chk_y does not overflow: the checker rejects any y beyond the floor.
  - chk_ack may arrive in the same cycle chk_req first rises only if the checker is combinational; the block must accept an ack in that cycle.
- Reset mid-CHECK: return immediately to IDLE. A late chk_ack arriving afterwards is ignored.
- A `tick_gravity` pulse during LOCK or SPAWN sets the down flag. It is serviced once FALLING is reached.

Test Plan:
1. Reset, then `start`, with checker always hit=0 and ack after 2 cycles → chk_req after 1 cycle at (3,0,0); active=1; each tick_gravity advances piece_y by 1 (0→1→2).
2. piece_x=0, pulse move_left → no chk_req, piece_x stays 0. Pulse move_right with hit=0 → piece_x=1.
3. tick_gravity and move_left in the same cycle at (3,5,0) → down check (3,6,0) is issued first, then left check (2,6,0); final position (2,6,0).
4. LOCK_TICKS=2, checker returns hit=1 for every down → first rejected tick gives no lock; second gives `lock` high for exactly 1 cycle with piece_y unchanged; a new spawn check at (3,0,0) follows.
5. Spawn check returns hit=1 → game_over=1 and active=0; further ticks and moves are ignored; `start` clears game_over and re-spawns.
6. Assert reset while chk_req=1 and ack pending, then deliver the ack → all outputs at reset values, state IDLE, ack has no effect.

Source files
------------

// File: rtl/gravity_fall_ctrl.sv
// Active-piece controller: applies gravity and player moves to the falling piece.
// Every candidate position is validated by the board collision checker before it is taken.
module gravity_fall_ctrl #(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned SPAWN_X    = 3,
   parameter int unsigned SPAWN_Y    = 0,
   parameter int unsigned LOCK_TICKS = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       tick_gravity,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       rotate,
   output logic       chk_req,
   output logic [3:0] chk_x,
   output logic [4:0] chk_y,
   output logic [1:0] chk_rot,
   input  logic       chk_ack,
   input  logic       chk_hit,
   output logic [3:0] piece_x,
   output logic [4:0] piece_y,
   output logic [1:0] piece_rot,
   output logic       active,
   output logic       lock,
   output logic       game_over
);
   localparam int unsigned XW = 4;
   localparam int unsigned YW = 5;
   localparam int unsigned RW = 2;
   localparam int unsigned CW = 3;
   localparam int unsigned NF = 4;
   localparam int unsigned F_DOWN  = 0;
   localparam int unsigned F_LEFT  = 1;
   localparam int unsigned F_RIGHT = 2;
   localparam int unsigned F_ROT   = 3;

   localparam logic [XW-1:0] SPAWN_XV  = XW'(SPAWN_X);
   localparam logic [YW-1:0] SPAWN_YV  = YW'(SPAWN_Y);
   localparam logic [XW-1:0] X_MAX     = XW'(BOARD_W - 1);
   localparam logic [CW-1:0] LOCK_CNTV = CW'(LOCK_TICKS);

   typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALLING, S_CHECK, S_LOCK, S_OVER} state_t;
   typedef enum logic [1:0] {OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROT} op_t;

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [NF-1:0] pend_q, pend_d, pulse_c, clr_c;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d, cnt_inc_c;
   logic [XW-1:0] piece_x_q, piece_x_d, chk_x_q, chk_x_d, cand_x_c;
   logic [YW-1:0] piece_y_q, piece_y_d, chk_y_q, chk_y_d, cand_y_c;
   logic [RW-1:0] piece_rot_q, piece_rot_d, chk_rot_q, chk_rot_d, cand_rot_c;
   logic          chk_req_q, chk_req_d;
   logic          active_q, active_d, lock_q, lock_d, game_over_q, game_over_d;
   logic          issue_c, spawn_c;
   op_t           cand_op_c;

   assign pulse_c   = {rotate, move_right, move_left, tick_gravity};
   assign cnt_inc_c = lock_cnt_q + 1'b1;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_DOWN;
         pend_q      <= '0;
         lock_cnt_q  <= '0;
         piece_x_q   <= SPAWN_XV;
         piece_y_q   <= SPAWN_YV;
         piece_rot_q <= '0;
         chk_x_q     <= '0;
         chk_y_q     <= '0;
         chk_rot_q   <= '0;
         chk_req_q   <= 1'b0;
         active_q    <= 1'b0;
         lock_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pend_q      <= pend_d;
         lock_cnt_q  <= lock_cnt_d;
         piece_x_q   <= piece_x_d;
         piece_y_q   <= piece_y_d;
         piece_rot_q <= piece_rot_d;
         chk_x_q     <= chk_x_d;
         chk_y_q     <= chk_y_d;
         chk_rot_q   <= chk_rot_d;
         chk_req_q   <= chk_req_d;
         active_q    <= active_d;
         lock_q      <= lock_d;
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lock_cnt_d  = lock_cnt_q;
      piece_x_d   = piece_x_q;
      piece_y_d   = piece_y_q;
      piece_rot_d = piece_rot_q;
      chk_x_d     = chk_x_q;
      chk_y_d     = chk_y_q;
      chk_rot_d   = chk_rot_q;
      chk_req_d   = chk_req_q;
      lock_d      = 1'b0;
      clr_c       = '0;
      issue_c     = 1'b0;
      spawn_c     = 1'b0;
      cand_op_c   = OP_DOWN;
      cand_x_c    = piece_x_q;
      cand_y_c    = piece_y_q;
      cand_rot_c  = piece_rot_q;

      case (state_q)
         S_IDLE, S_OVER: spawn_c = start;
         S_SPAWN: begin
            if (chk_ack) begin
               chk_req_d = 1'b0;
               state_d   = chk_hit ? S_OVER : S_FALLING;
            end
         end
         S_FALLING: begin
            // Priority down > left > right > rot; edge-of-board laterals are dropped locally
            if (pend_q[F_DOWN]) begin
               clr_c[F_DOWN] = 1'b1;
               issue_c       = 1'b1;
               cand_op_c     = OP_DOWN;
               cand_y_c      = piece_y_q + 1'b1;
            end else if (pend_q[F_LEFT]) begin
               clr_c[F_LEFT] = 1'b1;
               issue_c       = (piece_x_q != '0);
               cand_op_c     = OP_LEFT;
               cand_x_c      = piece_x_q - 1'b1;
            end else if (pend_q[F_RIGHT]) begin
               clr_c[F_RIGHT] = 1'b1;
               issue_c        = (piece_x_q != X_MAX);
               cand_op_c      = OP_RIGHT;
               cand_x_c       = piece_x_q + 1'b1;
            end else if (pend_q[F_ROT]) begin
               clr_c[F_ROT] = 1'b1;
               issue_c      = 1'b1;
               cand_op_c    = OP_ROT;
               cand_rot_c   = piece_rot_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (chk_ack) begin
               chk_req_d = 1'b0;
               state_d   = S_FALLING;
               if (!chk_hit) begin
                  piece_x_d   = chk_x_q;
                  piece_y_d   = chk_y_q;
                  piece_rot_d = chk_rot_q;
                  if (op_q == OP_DOWN) lock_cnt_d = '0;
               end else if (op_q == OP_DOWN) begin
                  lock_cnt_d = cnt_inc_c;
                  if (cnt_inc_c == LOCK_CNTV) begin
                     state_d = S_LOCK;
                     lock_d  = 1'b1;
                  end
               end
            end
         end
         S_LOCK:  spawn_c = 1'b1;
         default: state_d = S_IDLE;
      endcase

      if (issue_c) begin
         op_d      = cand_op_c;
         chk_x_d   = cand_x_c;
         chk_y_d   = cand_y_c;
         chk_rot_d = cand_rot_c;
         chk_req_d = 1'b1;
         state_d   = S_CHECK;
      end

      // New piece: load spawn position and immediately request its check
      if (spawn_c) begin
         state_d     = S_SPAWN;
         lock_cnt_d  = '0;
         piece_x_d   = SPAWN_XV;
         piece_y_d   = SPAWN_YV;
         piece_rot_d = '0;
         chk_x_d     = SPAWN_XV;
         chk_y_d     = SPAWN_YV;
         chk_rot_d   = '0;
         chk_req_d   = 1'b1;
      end

      if (state_q == S_IDLE || state_q == S_OVER) pend_d = '0;
      else if (state_q == S_LOCK)                 pend_d = pulse_c;
      else                                        pend_d = (pend_q | pulse_c) & ~clr_c;

      active_d    = (state_d == S_FALLING) || (state_d == S_CHECK);
      game_over_d = (state_d == S_OVER);
   end

   assign chk_req   = chk_req_q;
   assign chk_x     = chk_x_q;
   assign chk_y     = chk_y_q;
   assign chk_rot   = chk_rot_q;
   assign piece_x   = piece_x_q;
   assign piece_y   = piece_y_q;
   assign piece_rot = piece_rot_q;
   assign active    = active_q;
   assign lock      = lock_q;
   assign game_over = game_over_q;
endmodule
